// File: rtl/apb4_slave_regbank.sv
// APB4 completer with a bank of NUM_REGS byte-strobed registers, optional wait states
// and privilege filtering. Bus outputs are combinational and nonzero only in the PREADY cycle.
module apb4_slave_regbank #(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 32,
   parameter int NUM_REGS    = 16,
   parameter int WAIT_CYCLES = 0,
   parameter bit PRIV_ONLY   = 1'b0
) (
   input  logic                       PCLK,
   input  logic                       PRESET,
   input  logic                       PSEL,
   input  logic                       PENABLE,
   input  logic                       PWRITE,
   input  logic [ADDR_W-1:0]          PADDR,
   input  logic [DATA_W-1:0]          PWDATA,
   input  logic [DATA_W/8-1:0]        PSTRB,
   input  logic [2:0]                 PPROT,
   output logic [DATA_W-1:0]          PRDATA,
   output logic                       PREADY,
   output logic                       PSLVERR,
   output logic [NUM_REGS*DATA_W-1:0] regs_o
);

   localparam int NBYTES = DATA_W / 8;
   localparam int OFF_W  = $clog2(NBYTES);
   localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(NBYTES - 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t              state_q, state_d, phase;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                write_q, write_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [NBYTES-1:0]   strb_q, strb_d;
   logic                priv_q, priv_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [DATA_W-1:0]   regs_q [NUM_REGS];
   logic [DATA_W-1:0]   regs_d [NUM_REGS];

   logic [31:0]         idx;
   logic                err;
   logic                acc_ready;
   logic                violation;
   logic                do_write;
   logic [DATA_W-1:0]   rd_word;
   logic                unused_prot;

   assign unused_prot = ^PPROT[2:1];

   // The registered state never rests in SETUP: the address-phase cycle is recognised
   // directly from the bus so that the first ACCESS cycle is the one right after it.
   always_comb begin
      phase = state_q;
      if (state_q == IDLE && PSEL && !PENABLE) begin
         phase = SETUP;
      end
   end

   always_comb begin
      idx = 32'(addr_q >> OFF_W);
      err = (idx >= 32'(NUM_REGS)) || ((addr_q & ALIGN_MASK) != '0) || (PRIV_ONLY && !priv_q);
   end

   assign violation = (state_q == IDLE) && PSEL && PENABLE && !PRESET;
   assign acc_ready = (state_q == ACCESS) && PSEL && PENABLE && (cnt_q == 4'(WAIT_CYCLES));
   assign do_write  = acc_ready && write_q && !err;

   always_comb begin
      rd_word = '0;
      for (int k = 0; k < NUM_REGS; k++) begin
         if (idx == 32'(k)) begin
            rd_word = regs_q[k];
         end
      end
   end

   assign PREADY  = acc_ready || violation;
   assign PSLVERR = violation || (acc_ready && err);
   assign PRDATA  = (acc_ready && !write_q && !err) ? rd_word : '0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      write_d = write_q;
      wdata_d = wdata_q;
      strb_d  = strb_q;
      priv_d  = priv_q;
      case (phase)
         SETUP: begin
            state_d = ACCESS;
            cnt_d   = '0;
            addr_d  = PADDR;
            write_d = PWRITE;
            wdata_d = PWDATA;
            strb_d  = PSTRB;
            priv_d  = PPROT[0];
         end
         ACCESS: begin
            // Dropping PSEL before completion abandons the transfer.
            if (!PSEL || acc_ready) begin
               state_d = IDLE;
            end else if (cnt_q != 4'(WAIT_CYCLES)) begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      for (int k = 0; k < NUM_REGS; k++) begin
         regs_d[k] = regs_q[k];
         for (int b = 0; b < NBYTES; b++) begin
            if (do_write && idx == 32'(k) && strb_q[b]) begin
               regs_d[k][b*8 +: 8] = wdata_q[b*8 +: 8];
            end
         end
      end
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         write_q <= 1'b0;
         wdata_q <= '0;
         strb_q  <= '0;
         priv_q  <= 1'b0;
         for (int k = 0; k < NUM_REGS; k++) begin
            regs_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         write_q <= write_d;
         wdata_q <= wdata_d;
         strb_q  <= strb_d;
         priv_q  <= priv_d;
         for (int k = 0; k < NUM_REGS; k++) begin
            regs_q[k] <= regs_d[k];
         end
      end
   end

   for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
      assign regs_o[gi*DATA_W +: DATA_W] = regs_q[gi];
   end

endmodule

// File: tb/tb_apb4_slave_regbank.sv
// Randomized and directed bench for apb4_slave_regbank: two instances (no waits / unprivileged
// allowed, and 3 wait states / privileged only) checked against an array-based register model.
module tb_apb4_slave_regbank;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int NR = 16;

   logic            PCLK = 1'b0;
   logic            PRESET;
   logic [1:0]      psel;
   logic            penable, pwrite;
   logic [AW-1:0]   paddr;
   logic [DW-1:0]   pwdata;
   logic [3:0]      pstrb;
   logic [2:0]      pprot;
   logic [DW-1:0]   prdata0, prdata1;
   logic            pready0, pready1, pslverr0, pslverr1;
   logic [NR*DW-1:0] regs0, regs1;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] mregs [2][NR];

   always #5 PCLK = ~PCLK;

   apb4_slave_regbank #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .WAIT_CYCLES(0), .PRIV_ONLY(1'b0)) dut0 (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[0]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
      .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0), .regs_o(regs0));

   apb4_slave_regbank #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .WAIT_CYCLES(3), .PRIV_ONLY(1'b1)) dut1 (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel[1]), .PENABLE(penable), .PWRITE(pwrite),
      .PADDR(paddr), .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot),
      .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1), .regs_o(regs1));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic rdy(input int d);
      return (d == 1) ? pready1 : pready0;
   endfunction
   function automatic logic serr(input int d);
      return (d == 1) ? pslverr1 : pslverr0;
   endfunction
   function automatic logic [31:0] rdat(input int d);
      return (d == 1) ? prdata1 : prdata0;
   endfunction
   function automatic logic [31:0] reg_of(input int d, input int k);
      return (d == 1) ? regs1[k*32 +: 32] : regs0[k*32 +: 32];
   endfunction

   task automatic check_regs(input string tag);
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < NR; k++)
            chk($sformatf("%s dut%0d reg%0d", tag, d, k), reg_of(d, k), mregs[d][k]);
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++)
         for (int k = 0; k < NR; k++)
            mregs[d][k] = 32'h0;
   endtask

   task automatic idle_cycle();
      @(posedge PCLK); #1;
      psel = 2'b00; penable = 1'b0;
      check_regs("idle");
   endtask

   // One complete transfer; the next call starts its setup right after this PREADY cycle.
   task automatic xfer(input int d, input bit wr, input logic [AW-1:0] a, input logic [31:0] wd,
                       input logic [3:0] st, input logic [2:0] pr, output logic [31:0] rd_o,
                       output logic err_o);
      int idx, n, waits;
      bit merr, got_rdy;
      logic [31:0] exp_rd;
      idx   = int'(a >> 2);
      merr  = (idx >= NR) || (a[1:0] != 2'b00) || (d == 1 && !pr[0]);
      waits = (d == 1) ? 3 : 0;
      @(posedge PCLK); #1;
      psel = (d == 1) ? 2'b10 : 2'b01; penable = 1'b0;
      pwrite = wr; paddr = a; pwdata = wd; pstrb = st; pprot = pr;
      check_regs("pre");
      @(negedge PCLK);
      chk("setup_pready", rdy(d), 1'b0);
      chk("setup_prdata", rdat(d), 32'h0);
      @(posedge PCLK); #1;
      penable = 1'b1;
      // Scrambled bus values in ACCESS must be ignored in favour of the SETUP capture.
      paddr = AW'($urandom); pwdata = $urandom; pstrb = 4'($urandom); pprot = 3'($urandom);
      pwrite = 1'($urandom);
      n = 0; got_rdy = 1'b0;
      while (!got_rdy && n <= 20) begin
         @(negedge PCLK);
         if (rdy(d)) got_rdy = 1'b1;
         else begin
            chk("wait_pslverr", serr(d), 1'b0);
            chk("wait_prdata", rdat(d), 32'h0);
            n++;
            @(posedge PCLK); #1;
         end
      end
      chk("pready_seen", got_rdy, 1'b1);
      chk("latency", n, waits);
      exp_rd = (!wr && !merr) ? mregs[d][idx] : 32'h0;
      rd_o  = rdat(d);
      err_o = serr(d);
      chk("prdata", rd_o, exp_rd);
      chk("pslverr", err_o, merr);
      if (wr && !merr)
         for (int b = 0; b < 4; b++)
            if (st[b]) mregs[d][idx][b*8 +: 8] = wd[b*8 +: 8];
      $display("xfer dut%0d %s addr=%03h wdata=%08h strb=%h prot=%0d -> rdata=%08h err=%0d wait=%0d",
               d, wr ? "WR" : "RD", a, wd, st, pr, rd_o, err_o, n);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      logic [AW-1:0] a;
      int r;
      PRESET = 1'b1; psel = 2'b00; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
      model_reset();
      repeat (2) @(posedge PCLK);
      @(negedge PCLK);
      check_regs("reset");
      chk("reset_pready0", pready0, 1'b0);
      chk("reset_pready1", pready1, 1'b0);
      @(posedge PCLK); #1;
      PRESET = 1'b0;

      // Write then read back with zero wait states.
      xfer(0, 1'b1, 12'h004, 32'hA5A5_5A5A, 4'hF, 3'b000, rd, er);
      xfer(0, 1'b0, 12'h004, 32'h0, 4'h0, 3'b000, rd, er);
      chk("req036_rdata", rd, 32'hA5A5_5A5A);

      // Partial strobes.
      xfer(0, 1'b1, 12'h000, 32'h1122_3344, 4'hF, 3'b000, rd, er);
      xfer(0, 1'b1, 12'h000, 32'hFFFF_FFFF, 4'b0101, 3'b000, rd, er);
      idle_cycle();
      chk("req037_reg0", reg_of(0, 0), 32'h11FF_33FF);
      xfer(0, 1'b1, 12'h000, 32'hDEAD_BEEF, 4'b0000, 3'b000, rd, er);
      chk("zero_strb_err", er, 1'b0);

      // Wait states and error responses.
      xfer(1, 1'b1, 12'h008, 32'hCAFE_F00D, 4'hF, 3'b001, rd, er);
      xfer(1, 1'b0, 12'h008, 32'h0, 4'h0, 3'b001, rd, er);
      chk("wait_read", rd, 32'hCAFE_F00D);
      xfer(0, 1'b1, 12'h040, 32'h1234_5678, 4'hF, 3'b000, rd, er);
      xfer(0, 1'b1, 12'h002, 32'h1234_5678, 4'hF, 3'b000, rd, er);
      xfer(1, 1'b1, 12'h00C, 32'h1234_5678, 4'hF, 3'b000, rd, er);
      xfer(1, 1'b0, 12'h008, 32'h0, 4'h0, 3'b000, rd, er);
      chk("priv_err", er, 1'b1);
      idle_cycle();

      // Abort: PSEL dropped in the second ACCESS cycle.
      @(posedge PCLK); #1;
      psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 12'h010; pwdata = 32'h5555_AAAA;
      pstrb = 4'hF; pprot = 3'b001;
      @(posedge PCLK); #1; penable = 1'b1;
      @(negedge PCLK); chk("abort_acc1_pready", pready1, 1'b0);
      @(posedge PCLK); #1; psel = 2'b00;
      @(negedge PCLK); chk("abort_pready", pready1, 1'b0);
      idle_cycle();
      idle_cycle();
      $display("xfer dut1 WR addr=010 aborted");
      xfer(1, 1'b0, 12'h010, 32'h0, 4'h0, 3'b001, rd, er);

      // Reset pulsed mid-ACCESS.
      @(posedge PCLK); #1;
      psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 12'h014; pwdata = 32'h7777_8888;
      pstrb = 4'hF; pprot = 3'b001;
      @(posedge PCLK); #1; penable = 1'b1;
      @(posedge PCLK); #3;
      PRESET = 1'b1;
      #1;
      model_reset();
      check_regs("midreset");
      chk("midreset_pready1", pready1, 1'b0);
      chk("midreset_pslverr1", pslverr1, 1'b0);
      chk("midreset_prdata1", prdata1, 32'h0);
      @(posedge PCLK); #1;
      PRESET = 1'b0; psel = 2'b00; penable = 1'b0;
      $display("xfer dut1 WR addr=014 abandoned by reset");
      xfer(1, 1'b1, 12'h014, 32'h0BAD_F00D, 4'hF, 3'b001, rd, er);
      idle_cycle();

      // PENABLE without a setup phase.
      @(posedge PCLK); #1;
      psel = 2'b01; penable = 1'b1; pwrite = 1'b1; paddr = 12'h018; pwdata = 32'hFFFF_FFFF;
      pstrb = 4'hF; pprot = 3'b000;
      @(negedge PCLK);
      chk("viol_pready", pready0, 1'b1);
      chk("viol_pslverr", pslverr0, 1'b1);
      chk("viol_prdata", prdata0, 32'h0);
      $display("xfer dut0 WR addr=018 protocol violation");
      xfer(0, 1'b1, 12'h018, 32'h0102_0304, 4'hF, 3'b000, rd, er);
      chk("after_viol_err", er, 1'b0);

      // Randomized traffic with occasional idle gaps.
      for (int t = 0; t < 150; t++) begin
         r = $urandom_range(0, 9);
         if (r < 7)       a = AW'($urandom_range(0, NR-1) * 4);
         else if (r == 7) a = AW'($urandom_range(NR, 1023) * 4);
         else if (r == 8) a = AW'($urandom_range(0, NR-1) * 4 + $urandom_range(1, 3));
         else             a = AW'($urandom);
         xfer($urandom_range(0, 1), 1'($urandom), a, $urandom, 4'($urandom),
              {2'($urandom), ($urandom_range(0, 3) != 0)}, rd, er);
         if ($urandom_range(0, 2) == 0) idle_cycle();
      end
      idle_cycle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
